key_debouncer: RTL and testbench

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/key_debouncer_if.sv | 28 ++
 rtl/key_debouncer.sv | 153 +++++++++++++++
 tb/tb_key_debouncer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/key_debouncer_if.sv
// Push-button debouncer signal bundle: raw key and repeat enable in,
// registered event pulses and debounced level out.
interface key_debouncer_if;
    logic key_i;
    logic rpt_en_i;
    logic press_o;
    logic rpt_o;
    logic release_o;
    logic held_o;

    modport master (
        output key_i,
        output rpt_en_i,
        input  press_o,
        input  rpt_o,
        input  release_o,
        input  held_o
    );

    modport slave (
        input  key_i,
        input  rpt_en_i,
        output press_o,
        output rpt_o,
        output release_o,
        output held_o
    );
endinterface

// File: rtl/key_debouncer.sv
// Active-low push-button debouncer with press/release pulses and optional
// auto-repeat, driven by one shared 26-bit cycle counter.
module key_debouncer #(
    parameter int unsigned DB_CYCLES  = 1000000,
    parameter int unsigned RPT_DELAY  = 50000000,
    parameter int unsigned RPT_PERIOD = 10000000
) (
    input  logic     clk100_i,
    input  logic     rstn_i,
    key_debouncer_if.slave kb
);

    localparam logic [25:0] DB_LAST    = 26'(DB_CYCLES - 1);
    localparam logic [25:0] DELAY_LAST = 26'(RPT_DELAY - 1);
    localparam logic [25:0] PER_LAST   = 26'(RPT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    state_t      state_reg, state_next;
    logic [25:0] cnt_reg, cnt_next;
    logic [1:0]  sync_reg;
    logic        press_reg, press_next;
    logic        rpt_reg, rpt_next;
    logic        release_reg, release_next;
    logic        held_reg, held_next;
    logic        pressed_s;

    // Synchronizer resets to "released" so a key held through reset still debounces.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], kb.key_i};
        end
    end

    assign pressed_s = ~sync_reg[1];

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            rpt_reg     <= 1'b0;
            release_reg <= 1'b0;
            held_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            press_reg   <= press_next;
            rpt_reg     <= rpt_next;
            release_reg <= release_next;
            held_reg    <= held_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        rpt_next     = 1'b0;
        release_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pressed_s) begin
                    state_next = DB_PRESS;
                    cnt_next   = '0;
                end
            end

            DB_PRESS: begin
                if (!pressed_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 26'd1;
                end
            end

            HELD: begin
                if (!pressed_s) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (rpt_en_i_q() && cnt_reg == DELAY_LAST) begin
                    state_next = REPEAT;
                    cnt_next   = '0;
                    rpt_next   = 1'b1;
                end else if (cnt_reg != DELAY_LAST) begin
                    // Saturate so re-enabling repeat after the delay fires at once.
                    cnt_next = cnt_reg + 26'd1;
                end
            end

            REPEAT: begin
                if (!pressed_s) begin
                    state_next = DB_RELEASE;
                    cnt_next   = '0;
                end else if (!rpt_en_i_q()) begin
                    state_next = HELD;
                    cnt_next   = DELAY_LAST;
                end else if (cnt_reg == PER_LAST) begin
                    cnt_next = '0;
                    rpt_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 26'd1;
                end
            end

            DB_RELEASE: begin
                if (pressed_s) begin
                    // Release bounce: back to held without a fresh press event.
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == DB_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 26'd1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        held_next = (state_next == HELD) || (state_next == REPEAT) ||
                    (state_next == DB_RELEASE);
    end

    function automatic logic rpt_en_i_q();
        return kb.rpt_en_i;
    endfunction

    assign kb.press_o   = press_reg;
    assign kb.rpt_o     = rpt_reg;
    assign kb.release_o = release_reg;
    assign kb.held_o    = held_reg;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3;
// outputs are compared as {press, rpt, release, held}.
module tb_key_debouncer;

    logic clk100_i = 1'b0;
    logic rstn_i   = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    key_debouncer_if bus ();

    key_debouncer #(
        .DB_CYCLES (4),
        .RPT_DELAY (10),
        .RPT_PERIOD(3)
    ) dut (
        .clk100_i(clk100_i),
        .rstn_i  (rstn_i),
        .kb      (bus)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.press_o, bus.rpt_o, bus.release_o, bus.held_o};
        vectors++;
        $display("vec %0d %s: observed=%b expected=%b", vectors, tag, obs, exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick_chk(input string tag, input logic [3:0] exp);
        @(posedge clk100_i);
        #1;
        chk(tag, exp);
    endtask

    task automatic ticks_chk(input string tag, input int n, input logic [3:0] exp);
        for (int i = 0; i < n; i++) tick_chk(tag, exp);
    endtask

    initial begin
        bus.key_i    = 1'b0;
        bus.rpt_en_i = 1'b0;

        // Reset with the key already pressed
        #2 rstn_i = 1'b0;
        #1 chk("rst_async", 4'b0000);
        ticks_chk("rst_hold", 3, 4'b0000);
        #1 rstn_i = 1'b1;
        tick_chk("rst_first_edge", 4'b0000);
        ticks_chk("rst_db_wait", 5, 4'b0000);
        tick_chk("rst_press", 4'b1001);
        tick_chk("rst_held", 4'b0001);

        // Release after reset press
        bus.key_i = 1'b1;
        ticks_chk("rel0_wait", 6, 4'b0001);
        tick_chk("rel0_pulse", 4'b0010);
        ticks_chk("rel0_idle", 3, 4'b0000);

        // Clean press, 20 cycles, repeat disabled
        bus.key_i = 1'b0;
        ticks_chk("press_wait", 6, 4'b0000);
        tick_chk("press_pulse", 4'b1001);
        ticks_chk("press_held", 13, 4'b0001);
        bus.key_i = 1'b1;
        ticks_chk("rel_wait", 6, 4'b0001);
        tick_chk("rel_pulse", 4'b0010);
        ticks_chk("rel_idle", 3, 4'b0000);

        // Two-cycle bounce: nothing accepted
        bus.key_i = 1'b0;
        ticks_chk("bounce_low", 2, 4'b0000);
        bus.key_i = 1'b1;
        ticks_chk("bounce_quiet", 8, 4'b0000);

        // Auto-repeat: press at k+6, repeats at k+16, k+19, k+22
        bus.rpt_en_i = 1'b1;
        bus.key_i    = 1'b0;
        ticks_chk("ar_wait", 6, 4'b0000);
        tick_chk("ar_press", 4'b1001);
        ticks_chk("ar_delay", 9, 4'b0001);
        tick_chk("ar_rpt1", 4'b0101);
        ticks_chk("ar_per1", 2, 4'b0001);
        tick_chk("ar_rpt2", 4'b0101);
        ticks_chk("ar_per2", 2, 4'b0001);
        tick_chk("ar_rpt3", 4'b0101);

        // Disable repeat: pulses stop, level stays
        bus.rpt_en_i = 1'b0;
        ticks_chk("ar_off", 10, 4'b0001);
        // Re-enable: counter sits saturated, so the next edge repeats
        bus.rpt_en_i = 1'b1;
        tick_chk("ar_reen_rpt", 4'b0101);
        ticks_chk("ar_reen_per", 2, 4'b0001);
        tick_chk("ar_reen_rpt2", 4'b0101);
        bus.rpt_en_i = 1'b0;
        tick_chk("ar_off2", 4'b0001);

        // Release bounce: two high samples, then low again
        bus.key_i = 1'b1;
        ticks_chk("rb_high", 2, 4'b0001);
        bus.key_i = 1'b0;
        ticks_chk("rb_back_held", 10, 4'b0001);

        // Back into REPEAT: HELD cnt reaches 9 two edges later
        bus.rpt_en_i = 1'b1;
        ticks_chk("mr_delay", 2, 4'b0001);
        tick_chk("mr_rpt", 4'b0101);
        tick_chk("mr_in_repeat", 4'b0001);

        // Reset mid-repeat with key held
        #2 rstn_i = 1'b0;
        #1 chk("mr_rst_async", 4'b0000);
        tick_chk("mr_rst_hold", 4'b0000);
        #1 rstn_i = 1'b1;
        bus.rpt_en_i = 1'b0;
        ticks_chk("mr_db_wait", 6, 4'b0000);
        tick_chk("mr_press", 4'b1001);
        ticks_chk("mr_no_release", 4, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
